aes_word_sequencer: RTL and testbench
=====================================

# aes_word_sequencer

Sequencing front/back end for the combinational AES-128 encrypt core. Packs a 32-bit word stream into the 128-bit key and plaintext buses that drive the core, and holds them stable for a fixed settle window. It then captures the 128-bit ciphertext and streams it back out as four 32-bit words. It sits between the AXI register/stream logic of the IP and the encrypt datapath.

## Interface
- SETTLE_CYCLES, 4, cycles the core's inputs are held stable before ciphertext capture; legal range 1..15
- s00_axi_aclk  in  1  sole clock, all logic on rising edge
- s00_axi_aresetn  in  1  reset, synchronous, active-low
- in_data  in  32  input word
- in_is_key  in  1  1 = key word, 0 = plaintext word
- in_valid  in  1  input word valid
- in_ready  out  1  sequencer can accept a word
- out_data  out  32  ciphertext word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts word
- out_last  out  1  marks 4th (final) ciphertext word
- plaintext  out  128  to encrypt core
- cipher_key  out  128  to encrypt core
- ciphertext  in  128  from encrypt core (combinational)
- busy  out  1  high in SETTLE or UNLOAD
- err_seq  out  1  sticky: interrupted key/plaintext sequence
- err_nokey  out  1  sticky: plaintext completed with no key loaded

## Operation
- Word order is MSW first: 1st word -> [127:96], 4th -> [31:0], for key, plaintext and ciphertext alike.
- Handshake: a transfer occurs on a clock edge where valid && ready are both high. valid must not depend on ready.
- State LOAD:
  - in_ready = 1 (gated by s00_axi_aresetn); out_valid = 0.
  - A key word goes into the key shadow at index key_cnt, and key_cnt increments.
  - On the 4th key word, the shadow commits to cipher_key, key_loaded is set, and key_cnt returns to 0.
  - A plaintext word writes plaintext[index pt_cnt] directly, and pt_cnt increments.
  - On the 4th plaintext word: if key_loaded, go to SETTLE with the settle counter = SETTLE_CYCLES-1. Otherwise drop the block, set err_nokey, pt_cnt = 0, and stay in LOAD.
- Interleave errors:
  - Key word accepted while pt_cnt != 0: pt_cnt is cleared and err_seq is set; the key word is still processed.
  - Plaintext word accepted while key_cnt != 0: key_cnt is cleared, the shadow is discarded, and err_seq is set. cipher_key and key_loaded are unchanged, and the word is still processed.
- State SETTLE:
  - in_ready = 0. The counter decrements once per cycle.
  - On the edge where the counter is 0, capture ciphertext into the output register, clear the word index, and go to UNLOAD.
- State UNLOAD:
  - out_valid = 1 and out_data = word[idx]; out_last = (idx == 3).
  - Each out handshake increments idx. The handshake with out_last goes to LOAD.
  - out_data, out_last and out_valid stay stable while out_valid && !out_ready.
- The key persists across blocks. Any number of plaintext blocks may follow a single key load.
- err_seq and err_nokey clear only on reset.
- Reset (s00_axi_aresetn low at an edge), from any state including mid-SETTLE or mid-UNLOAD:
  - State goes to LOAD.
  - All counters, key_loaded, err flags, plaintext, cipher_key and the output register are cleared to 0.
  - Any partial or in-flight block is lost.
- Output values while reset is asserted: in_ready, out_valid, out_last, busy, err_seq and err_nokey = 0; out_data, plaintext and cipher_key = 0.

## Timing
- in_ready is 1 in the first cycle after s00_axi_aresetn deasserts.
- With the 4th plaintext word accepted at edge N:
  - plaintext is valid after N.
  - busy = 1 from N.
  - Ciphertext is captured at edge N+SETTLE_CYCLES.
  - out_valid = 1 from N+SETTLE_CYCLES.
- With out_ready held high, the four out words occupy cycles N+SETTLE_CYCLES .. N+SETTLE_CYCLES+3. in_ready = 1 again in the cycle after the last handshake.
- Minimum block period: 4 + SETTLE_CYCLES + 4 cycles. A key load adds 4 cycles.
- plaintext and cipher_key are held constant throughout SETTLE. The core must meet timing within SETTLE_CYCLES clock periods (multicycle constraint).
- No combinational path from in_valid or out_ready to any output except through the state register. in_ready and out_valid are functions of state only.

## Test plan
- Key 000102030405060708090a0b0c0d0e0f, then plaintext 00112233445566778899aabbccddeeff -> out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a. out_last is set on the 4th word only. out_valid rises exactly SETTLE_CYCLES edges after the 4th plaintext handshake.
- Key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734, with out_ready toggled 1/0 every cycle -> 3925841d 02dc09fb dc118597 196a0b32. Data stays stable while stalled. A second plaintext block sent with no new key also encrypts correctly.
- Plaintext sent with no key after reset -> no out_valid, err_nokey = 1, in_ready stays 1. A subsequent key plus the same plaintext then yields the correct ciphertext.
- 2 plaintext words, then 4 key words, then 4 plaintext words -> err_seq = 1; the ciphertext uses only the last 4 plaintext words and the new key.
- Reset asserted during SETTLE, and separately after the 2nd out word -> all outputs 0. in_ready = 1 the cycle after release. key_loaded is cleared, so plaintext sent alone sets err_nokey.
- SETTLE_CYCLES = 1 and 15, with the FIPS-197 C.1 vector -> latency of exactly 1 and 15 cycles respectively, with correct ciphertext in both cases.

Source files
------------

// File: rtl/aes_word_sequencer.sv
// aes_word_sequencer: packs a 32-bit word stream into the 128-bit key and
// plaintext buses of a combinational AES-128 core. It holds those buses
// stable for SETTLE_CYCLES cycles, captures the ciphertext, and streams it
// back out as four 32-bit words. Every word stream is most-significant word first.
module aes_word_sequencer #(
    parameter int SETTLE_CYCLES = 4   // legal range 1..15
) (
    input  logic         s00_axi_aclk,
    input  logic         s00_axi_aresetn,
    input  logic [31:0]  in_data,
    input  logic         in_is_key,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [127:0] plaintext,
    output logic [127:0] cipher_key,
    input  logic [127:0] ciphertext,
    output logic         busy,
    output logic         err_seq,
    output logic         err_nokey
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_UNLOAD = 2'd2
    } state_e;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_e        state_q, state_d;
    logic [1:0]    key_cnt_q, key_cnt_d;
    logic [1:0]    pt_cnt_q, pt_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    settle_q, settle_d;
    logic          key_loaded_q, key_loaded_d;
    logic          err_seq_q, err_seq_d;
    logic          err_nokey_q, err_nokey_d;
    logic [127:0]  key_shadow_q, key_shadow_d;
    logic [127:0]  cipher_key_q, cipher_key_d;
    logic [127:0]  plaintext_q, plaintext_d;
    logic [127:0]  out_reg_q, out_reg_d;

    logic          in_fire;
    logic          out_fire;
    logic [31:0]   out_word;

    // Handshakes are qualified by state alone, so ready never depends on valid.
    assign in_fire  = in_valid  && (state_q == ST_LOAD);
    assign out_fire = out_ready && (state_q == ST_UNLOAD);

    // Next-state and datapath updates for the load / settle / unload sequence.
    always_comb begin
        state_d      = state_q;
        key_cnt_d    = key_cnt_q;
        pt_cnt_d     = pt_cnt_q;
        idx_d        = idx_q;
        settle_d     = settle_q;
        key_loaded_d = key_loaded_q;
        err_seq_d    = err_seq_q;
        err_nokey_d  = err_nokey_q;
        key_shadow_d = key_shadow_q;
        cipher_key_d = cipher_key_q;
        plaintext_d  = plaintext_q;
        out_reg_d    = out_reg_q;

        unique case (state_q)
            ST_LOAD: begin
                if (in_fire && in_is_key) begin
                    // A key word arriving mid-plaintext aborts that block.
                    if (pt_cnt_q != 2'd0) begin
                        pt_cnt_d  = 2'd0;
                        err_seq_d = 1'b1;
                    end
                    // Word index n lands in bits [(3-n)*32 +: 32], i.e. MSW first.
                    key_shadow_d[{~key_cnt_q, 5'd0} +: 32] = in_data;
                    if (key_cnt_q == 2'd3) begin
                        cipher_key_d = key_shadow_d;
                        key_loaded_d = 1'b1;
                        key_cnt_d    = 2'd0;
                    end else begin
                        key_cnt_d = key_cnt_q + 2'd1;
                    end
                end else if (in_fire) begin
                    // A plaintext word mid-key discards the partial key; the
                    // committed key stays in force.
                    if (key_cnt_q != 2'd0) begin
                        key_cnt_d    = 2'd0;
                        key_shadow_d = '0;
                        err_seq_d    = 1'b1;
                    end
                    plaintext_d[{~pt_cnt_q, 5'd0} +: 32] = in_data;
                    if (pt_cnt_q == 2'd3) begin
                        pt_cnt_d = 2'd0;
                        if (key_loaded_q) begin
                            state_d  = ST_SETTLE;
                            settle_d = SETTLE_INIT;
                        end else begin
                            err_nokey_d = 1'b1;
                        end
                    end else begin
                        pt_cnt_d = pt_cnt_q + 2'd1;
                    end
                end
            end

            ST_SETTLE: begin
                // The core output is only trusted once the window has elapsed.
                if (settle_q == 4'd0) begin
                    out_reg_d = ciphertext;
                    idx_d     = 2'd0;
                    state_d   = ST_UNLOAD;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end

            ST_UNLOAD: begin
                if (out_fire) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_LOAD;
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and datapath registers; synchronous active-low reset clears everything.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state_q      <= ST_LOAD;
            key_cnt_q    <= 2'd0;
            pt_cnt_q     <= 2'd0;
            idx_q        <= 2'd0;
            settle_q     <= 4'd0;
            key_loaded_q <= 1'b0;
            err_seq_q    <= 1'b0;
            err_nokey_q  <= 1'b0;
            key_shadow_q <= '0;
            cipher_key_q <= '0;
            plaintext_q  <= '0;
            out_reg_q    <= '0;
        end else begin
            state_q      <= state_d;
            key_cnt_q    <= key_cnt_d;
            pt_cnt_q     <= pt_cnt_d;
            idx_q        <= idx_d;
            settle_q     <= settle_d;
            key_loaded_q <= key_loaded_d;
            err_seq_q    <= err_seq_d;
            err_nokey_q  <= err_nokey_d;
            key_shadow_q <= key_shadow_d;
            cipher_key_q <= cipher_key_d;
            plaintext_q  <= plaintext_d;
            out_reg_q    <= out_reg_d;
        end
    end

    // Output word select, MSW first.
    always_comb begin
        out_word = out_reg_q[{~idx_q, 5'd0} +: 32];
    end

    // Outputs come from registers only; the reset gate forces them to zero
    // during reset, before the first reset edge has been seen.
    assign in_ready   = s00_axi_aresetn && (state_q == ST_LOAD);
    assign out_valid  = s00_axi_aresetn && (state_q == ST_UNLOAD);
    assign out_last   = s00_axi_aresetn && (state_q == ST_UNLOAD) && (idx_q == 2'd3);
    assign busy       = s00_axi_aresetn && (state_q != ST_LOAD);
    assign err_seq    = s00_axi_aresetn && err_seq_q;
    assign err_nokey  = s00_axi_aresetn && err_nokey_q;
    assign out_data   = s00_axi_aresetn ? out_word     : 32'd0;
    assign plaintext  = s00_axi_aresetn ? plaintext_q  : 128'd0;
    assign cipher_key = s00_axi_aresetn ? cipher_key_q : 128'd0;

endmodule

// File: tb/tb_aes_word_sequencer.sv
// Bench for aes_word_sequencer: three instances (settle 4, 1, 15) share the
// stimulus bus; sel steers valid/ready to one instance and picks its outputs.
// The encrypt core is modelled by a lookup of the known FIPS-197 vectors.
module tb_aes_word_sequencer;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    function automatic int sc_of(int s);
        return (s == 0) ? 4 : (s == 1) ? 1 : 15;
    endfunction

    // Stand-in for the combinational AES core: exact for the known vectors,
    // deliberately wrong-looking for anything else.
    function automatic logic [127:0] aes_model(logic [127:0] k, logic [127:0] p);
        if (k == K1 && p == P1) return C1;
        if (k == K2 && p == P2) return C2;
        return k ^ {p[63:0], p[127:64]} ^ 128'hdeadbeef_0badf00d_5a5a5a5a_c3c3c3c3;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_is_key;
    logic        in_valid;
    logic        out_ready;
    int          sel;

    logic [2:0]         in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_last_w;
    logic [2:0]         busy_w, err_seq_w, err_nokey_w;
    logic [2:0][31:0]   out_data_w;
    logic [2:0][127:0]  pt_w, key_w, ct_w;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign in_valid_w[g]  = in_valid  && (sel == g);
        assign out_ready_w[g] = out_ready && (sel == g);
        assign ct_w[g]        = aes_model(key_w[g], pt_w[g]);
        aes_word_sequencer #(.SETTLE_CYCLES((g == 0) ? 4 : (g == 1) ? 1 : 15)) u_dut (
            .s00_axi_aclk    (clk),
            .s00_axi_aresetn (rst_n),
            .in_data         (in_data),
            .in_is_key       (in_is_key),
            .in_valid        (in_valid_w[g]),
            .in_ready        (in_ready_w[g]),
            .out_data        (out_data_w[g]),
            .out_valid       (out_valid_w[g]),
            .out_ready       (out_ready_w[g]),
            .out_last        (out_last_w[g]),
            .plaintext       (pt_w[g]),
            .cipher_key      (key_w[g]),
            .ciphertext      (ct_w[g]),
            .busy            (busy_w[g]),
            .err_seq         (err_seq_w[g]),
            .err_nokey       (err_nokey_w[g])
        );
    end

    wire        ir  = in_ready_w[sel];
    wire        ov  = out_valid_w[sel];
    wire        ol  = out_last_w[sel];
    wire [31:0] od  = out_data_w[sel];

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called from a negedge; word transfers on the next edge with ready high.
    task automatic send_word(input logic is_key, input logic [31:0] d);
        int t;
        in_data = d; in_is_key = is_key; in_valid = 1'b1;
        t = 0;
        while (!ir && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic is_key, input logic [127:0] d);
        for (int i = 0; i < 4; i++) send_word(is_key, d[127 - 32*i -: 32]);
    endtask

    // Starts at the negedge right after the 4th plaintext edge. Measures
    // latency to out_valid, collects four words, checks last and stall stability.
    task automatic recv(input string name, input logic toggle, input int exp_lat,
                        input logic [127:0] exp_pt, input logic [127:0] exp_ct);
        int lat, n, cyc;
        logic ph, stalled, hold_ok, last_ok, pt_ok;
        logic [31:0] prev_d;
        logic prev_l;
        logic [127:0] got;
        lat = 0; pt_ok = 1'b1;
        while (!ov && lat < 40) begin
            if (pt_w[sel] !== exp_pt) pt_ok = 1'b0;
            @(negedge clk); lat++;
        end
        chk({name, "_latency"}, 128'(lat), 128'(exp_lat));
        chk({name, "_pt_held"}, {127'd0, pt_ok}, 128'd1);
        n = 0; cyc = 0; ph = 1'b1; stalled = 1'b0; hold_ok = 1'b1; last_ok = 1'b1;
        got = '0; prev_d = '0; prev_l = 1'b0;
        while (n < 4 && cyc < 40) begin
            if (!ov) hold_ok = 1'b0;
            if (stalled && (od !== prev_d || ol !== prev_l)) hold_ok = 1'b0;
            out_ready = toggle ? ph : 1'b1;
            ph = ~ph;
            if (out_ready) begin
                got[127 - 32*n -: 32] = od;
                if (ol !== (n == 3)) last_ok = 1'b0;
                n++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
            end
            prev_d = od; prev_l = ol;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk({name, "_ct"}, got, exp_ct);
        chk({name, "_last_hold"}, {126'd0, hold_ok, last_ok}, 128'd3);
        chk({name, "_ready_after"}, {126'd0, ir, ov}, 128'd2);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_flags"}, {122'd0, ir, ov, ol, busy_w[sel], err_seq_w[sel], err_nokey_w[sel]}, 128'd0);
        chk({name, "_data"}, {96'd0, od}, 128'd0);
        chk({name, "_buses"}, pt_w[sel] | key_w[sel], 128'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Plaintext alone: must not produce output, must flag err_nokey.
    task automatic expect_nokey(input string name);
        logic quiet;
        send_block(1'b0, P1);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (ov || !ir) quiet = 1'b0;
            @(negedge clk);
        end
        chk({name, "_quiet"}, {127'd0, quiet}, 128'd1);
        chk({name, "_err_nokey"}, {127'd0, err_nokey_w[sel]}, 128'd1);
    endtask

    typedef struct {
        int           s;
        logic         load_key;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        logic         toggle;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{0, 1'b1, K1, P1, C1, 1'b0};
        vecs[1] = '{0, 1'b1, K2, P2, C2, 1'b1};
        vecs[2] = '{0, 1'b0, K2, P2, C2, 1'b1};   // key persists
        vecs[3] = '{1, 1'b1, K1, P1, C1, 1'b0};   // settle 1
        vecs[4] = '{2, 1'b1, K1, P1, C1, 1'b0};   // settle 15

        rst_n = 1'b0; in_data = '0; in_is_key = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; sel = 0;
        #1 check_zero("reset_async_view");
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        #1 chk("ready_after_reset", {127'd0, ir}, 128'd1);
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            sel = vecs[i].s;
            if (vecs[i].load_key) send_block(1'b1, vecs[i].key);
            send_block(1'b0, vecs[i].pt);
            chk($sformatf("vec%0d_busy", i), {126'd0, busy_w[sel], ir}, 128'd2);
            chk($sformatf("vec%0d_key", i), key_w[sel], vecs[i].key);
            recv($sformatf("vec%0d", i), vecs[i].toggle, sc_of(sel), vecs[i].pt, vecs[i].ct);
        end
        sel = 0;

        // No key after reset, then a proper key recovers.
        do_reset();
        expect_nokey("nokey");
        send_block(1'b1, K1);
        send_block(1'b0, P1);
        recv("nokey_recover", 1'b0, 4, P1, C1);

        // Interrupted plaintext, then key, then a full block.
        do_reset();
        begin
            logic [127:0] p2v;
            p2v = P2;
            send_word(1'b0, p2v[127:96]);
            send_word(1'b0, p2v[95:64]);
        end
        send_block(1'b1, K1);
        chk("interleave_err_seq", {126'd0, err_seq_w[sel], err_nokey_w[sel]}, 128'd2);
        send_block(1'b0, P1);
        recv("interleave", 1'b0, 4, P1, C1);

        // Reset mid-SETTLE.
        do_reset();
        send_block(1'b1, K1);
        send_block(1'b0, P1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_zero("rst_settle");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_settle_ready", {127'd0, ir}, 128'd1);
        @(negedge clk);
        expect_nokey("rst_settle_nokey");

        // Reset after the second output word.
        do_reset();
        send_block(1'b1, K1);
        send_block(1'b0, P1);
        begin
            int t;
            t = 0;
            while (!ov && t < 40) begin @(negedge clk); t++; end
            chk("rst_unload_valid", {127'd0, ov}, 128'd1);
        end
        out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1 check_zero("rst_unload");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_unload_ready", {127'd0, ir}, 128'd1);
        @(negedge clk);
        expect_nokey("rst_unload_nokey");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
